// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the stream reader.
// Pure wiring: no latency of its own.
// Backpressure is carried on m_ready; the FIFO side is throttled through fifo_rd_en.
interface fifo_stream_reader_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a 1-cycle-latency FIFO and re-presents its words on a valid/ready stream.
// Latency: pop issued at edge N gives m_valid/m_data after edge N+1; 1 word/cycle sustained.
// Backpressure: 2-entry buffer; pops are credit-limited so at most 2 words are buffered or in flight.
module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    fifo_stream_reader_if.master sif,
    output logic [CNT_W-1:0]     rd_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic              inflight;
    logic              valid_q;
    logic [DATA_W-1:0] head_dat;
    logic [DATA_W-1:0] tail_dat;
    logic [1:0]        occ;
    logic              pop;
    logic              credit_ok;
    logic              issue;

    assign occ = state;
    assign pop = valid_q && sif.m_ready;

    // occ + inflight - pop < 2, rearranged to stay unsigned
    assign credit_ok = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
    assign issue     = rst_n && en && !sif.fifo_empty && credit_ok;

    assign sif.fifo_rd_en = issue;
    assign sif.m_valid    = valid_q;
    assign sif.m_data     = head_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            inflight <= 1'b0;
            valid_q  <= 1'b0;
            head_dat <= '0;
            tail_dat <= '0;
            rd_count <= '0;
        end else begin
            inflight <= issue;
            if (pop) begin
                rd_count <= rd_count + CNT_W'(1);
            end
            case (state)
                EMPTY: begin
                    if (inflight) begin
                        head_dat <= sif.fifo_rd_data;
                        valid_q  <= 1'b1;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (inflight && !pop) begin
                        tail_dat <= sif.fifo_rd_data;
                        state    <= TWO;
                    end else if (inflight && pop) begin
                        head_dat <= sif.fifo_rd_data;
                    end else if (pop) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                TWO: begin
                    // capture without pop cannot happen here: credit rule blocks the issue
                    if (pop) begin
                        head_dat <= tail_dat;
                        if (inflight) begin
                            tail_dat <= sif.fifo_rd_data;
                        end else begin
                            state <= ONE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model drives two instances (CNT_W=4 and CNT_W=16).
// Scoreboard of words pushed into the FIFO; monitor checks order, valid, credit and counters.
// Stimulus covers directed scenarios then randomized en/m_ready with a mid-stream reset.
module tb_fifo_stream_reader;

    localparam int DATA_W = 8;

    logic clk;
    logic rst_n;
    logic en;
    logic [3:0]  rd_count_a;
    logic [15:0] rd_count_b;

    fifo_stream_reader_if #(.DATA_W(DATA_W)) sif_a ();
    fifo_stream_reader_if #(.DATA_W(DATA_W)) sif_b ();

    assign sif_b.fifo_empty   = sif_a.fifo_empty;
    assign sif_b.fifo_rd_data = sif_a.fifo_rd_data;
    assign sif_b.m_ready      = sif_a.m_ready;

    fifo_stream_reader #(.DATA_W(DATA_W), .CNT_W(4)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sif      (sif_a.master),
        .rd_count (rd_count_a)
    );

    fifo_stream_reader #(.DATA_W(DATA_W), .CNT_W(16)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sif      (sif_b.master),
        .rd_count (rd_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] fq[$];
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        sif_a.fifo_empty = 1'b0;
    endtask

    // One clock of the FIFO model: pop decided mid-cycle, read data presented just after the edge.
    task automatic step();
        bit dp;
        @(negedge clk);
        dp = sif_a.fifo_rd_en && !sif_a.fifo_empty;
        @(posedge clk);
        #1;
        if (dp && fq.size() > 0) sif_a.fifo_rd_data = fq.pop_front();
        else                     sif_a.fifo_rd_data = DATA_W'($urandom);
        sif_a.fifo_empty = (fq.size() == 0);
    endtask

    // Monitor: expected buffer fill = words popped from FIFO and already captured, minus delivered.
    initial begin
        int  iss;
        int  dlv;
        int  buffered;
        bit  last_pop;
        bit  exp_valid;
        bit  pop_now;
        bit  exp_rd_en;
        bit  cur;
        bit  prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic [DATA_W-1:0] w;
        iss = 0; dlv = 0; last_pop = 0; prev_stall = 0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_m_valid", 32'(sif_a.m_valid), 0);
                chk("rst_rd_en", 32'(sif_a.fifo_rd_en), 0);
                chk("rst_rd_count", 32'(rd_count_b), 0);
                for (int i = 0; i < iss - dlv; i++)
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                iss = 0; dlv = 0; last_pop = 0; prev_stall = 0;
            end else begin
                buffered  = iss - int'(last_pop) - dlv;
                exp_valid = (buffered > 0);
                if (buffered > 2) chk("occupancy_le_2", 32'(buffered), 2);
                chk("m_valid_a", 32'(sif_a.m_valid), 32'(exp_valid));
                chk("m_valid_b", 32'(sif_b.m_valid), 32'(exp_valid));
                pop_now   = exp_valid && sif_a.m_ready;
                exp_rd_en = en && !sif_a.fifo_empty &&
                            (buffered + int'(last_pop) - int'(pop_now)) < 2;
                chk("rd_en_a", 32'(sif_a.fifo_rd_en), 32'(exp_rd_en));
                chk("rd_en_b", 32'(sif_b.fifo_rd_en), 32'(exp_rd_en));
                chk("rd_count_w4", 32'(rd_count_a), 32'(dlv % 16));
                chk("rd_count_w16", 32'(rd_count_b), 32'(dlv % 65536));
                if (prev_stall) chk("stall_hold", 32'(sif_a.m_data), 32'(prev_data));
                if (pop_now) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 32'(sif_a.m_data), 32'hFFFF_FFFF);
                    end else begin
                        w = exp_q.pop_front();
                        chk("data_a", 32'(sif_a.m_data), 32'(w));
                        chk("data_b", 32'(sif_b.m_data), 32'(w));
                    end
                    dlv++;
                end
                prev_stall = sif_a.m_valid && !sif_a.m_ready;
                prev_data  = sif_a.m_data;
                cur        = sif_a.fifo_rd_en && !sif_a.fifo_empty;
                iss       += int'(cur);
                last_pop   = cur;
            end
        end
    end

    initial begin
        int budget;
        rst_n = 1'b0;
        en    = 1'b0;
        sif_a.m_ready      = 1'b0;
        sif_a.fifo_empty   = 1'b1;
        sif_a.fifo_rd_data = '0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // single word
        en = 1'b1;
        sif_a.m_ready = 1'b1;
        push(8'hA5);
        repeat (5) step();
        chk("single_count", 32'(rd_count_b), 1);

        // streaming 0x01..0x10
        for (int i = 1; i <= 16; i++) push(DATA_W'(i));
        repeat (20) step();
        chk("stream_count", 32'(rd_count_b), 17);
        chk("wrap_count", 32'(rd_count_a), 1);

        // backpressure: exactly two pops while stalled
        sif_a.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(DATA_W'(8'h40 + i));
        repeat (8) step();
        chk("bp_fifo_left", 32'(fq.size()), 4);
        sif_a.m_ready = 1'b1;
        repeat (10) step();
        chk("bp_count", 32'(rd_count_b), 23);

        // en drop one cycle after a pop issue
        en = 1'b0;
        for (int i = 0; i < 3; i++) push(DATA_W'(8'h70 + i));
        repeat (2) step();
        en = 1'b1;
        step();
        en = 1'b0;
        repeat (6) step();
        chk("en_drop_fifo_left", 32'(fq.size()), 2);
        chk("en_drop_count", 32'(rd_count_b), 24);
        en = 1'b1;
        repeat (6) step();

        // randomized traffic with a mid-stream reset
        for (int c = 0; c < 600; c++) begin
            if (($urandom % 2) == 0 && fq.size() < 20) push(DATA_W'($urandom));
            en            = ($urandom % 4) != 0;
            sif_a.m_ready = ($urandom % 3) != 0;
            if (c == 300) begin
                rst_n = 1'b0;
                #1;
                chk("async_rst_valid", 32'(sif_a.m_valid), 0);
                chk("async_rst_rd_en", 32'(sif_a.fifo_rd_en), 0);
                chk("async_rst_count_a", 32'(rd_count_a), 0);
                chk("async_rst_count_b", 32'(rd_count_b), 0);
                repeat (2) step();
                rst_n = 1'b1;
            end
            step();
        end

        // drain
        en = 1'b1;
        sif_a.m_ready = 1'b1;
        budget = 0;
        while ((fq.size() != 0 || exp_q.size() != 0) && budget < 200) begin
            step();
            budget++;
        end
        chk("drain_timeout", 32'(budget < 200), 1);
        chk("drain_empty", 32'(exp_q.size()), 0);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
